// File: rtl/code_loader_if.sv
// Byte-stream input and code-RAM write port bundle for code_loader.
// master = loader side, slave = byte source / code RAM / processor side.
interface code_loader_if #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
);
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 code_we;
   logic [ADDR_SIZE-1:0] code_addr;
   logic [WORD_SIZE-1:0] code_din;
   logic                 processor_reset;
   logic                 done;
   logic                 error;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, code_we, code_addr, code_din, processor_reset, done, error
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, code_we, code_addr, code_din, processor_reset, done, error
   );
endinterface

// File: rtl/code_loader.sv
// Framed byte-stream loader: A5, count_lo, count_hi, then 3-byte words written to code RAM.
// Define CODE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module code_loader #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18,
   parameter int MEM_SIZE  = 1024
) (
   input  logic          clock,
   input  logic          reset,
   code_loader_if.master bus
);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [3:0] {
      IDLE, CNT_LO, CNT_HI, B0, B1, B2, CSUM, DONE, ERR
   } state_t;

   state_t               state_reg;
   logic [15:0]          count_reg;
   logic [15:0]          word_cnt_reg;
   logic [7:0]           b0_reg;
   logic [7:0]           b1_reg;
   logic                 code_we_reg;
   logic [ADDR_SIZE-1:0] code_addr_reg;
   logic [WORD_SIZE-1:0] code_din_reg;
   logic                 processor_reset_reg;
   logic                 done_reg;
   logic                 error_reg;

   logic [7:0]  rx;
   logic        is_sync;
   logic [15:0] count_full;

   assign rx         = bus.rx_data;
   assign is_sync    = (rx == SYNC_BYTE);
   assign count_full = {rx, count_reg[7:0]};

`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0] csum_reg;

   // Running XOR starts fresh with count_lo, so the sync byte never contributes.
   always_ff @(posedge clock) begin
      if (reset) begin
         csum_reg <= 8'h00;
      end else if (bus.rx_valid) begin
         case (state_reg)
            CNT_LO:             csum_reg <= rx;
            CNT_HI, B0, B1, B2: csum_reg <= csum_reg ^ rx;
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg           <= IDLE;
         count_reg           <= '0;
         word_cnt_reg        <= '0;
         b0_reg              <= '0;
         b1_reg              <= '0;
         code_we_reg         <= 1'b0;
         code_addr_reg       <= '0;
         code_din_reg        <= '0;
         processor_reset_reg <= 1'b1;
         done_reg            <= 1'b0;
         error_reg           <= 1'b0;
      end else begin
         code_we_reg <= 1'b0;
         if (bus.rx_valid) begin
            case (state_reg)
               IDLE: begin
                  if (is_sync) state_reg <= CNT_LO;
               end
               CNT_LO: begin
                  count_reg[7:0] <= rx;
                  state_reg      <= CNT_HI;
               end
               CNT_HI: begin
                  count_reg    <= count_full;
                  word_cnt_reg <= '0;
                  if (count_full == 16'd0 || 32'(count_full) > MEM_SIZE) begin
                     state_reg <= ERR;
                     error_reg <= 1'b1;
                  end else begin
                     state_reg <= B0;
                  end
               end
               B0: begin
                  b0_reg    <= rx;
                  state_reg <= B1;
               end
               B1: begin
                  b1_reg    <= rx;
                  state_reg <= B2;
               end
               B2: begin
                  if (rx[7:2] != 6'd0) begin
                     state_reg <= ERR;
                     error_reg <= 1'b1;
                  end else begin
                     code_we_reg   <= 1'b1;
                     code_addr_reg <= ADDR_SIZE'(word_cnt_reg);
                     code_din_reg  <= WORD_SIZE'({rx[1:0], b1_reg, b0_reg});
                     word_cnt_reg  <= word_cnt_reg + 16'd1;
                     if (word_cnt_reg == count_reg - 16'd1) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                        state_reg <= CSUM;
`else
                        state_reg           <= DONE;
                        done_reg            <= 1'b1;
                        processor_reset_reg <= 1'b0;
`endif
                     end else begin
                        state_reg <= B0;
                     end
                  end
               end
`ifdef CODE_LOADER_CHECKSUM_EN
               CSUM: begin
                  if (rx == csum_reg) begin
                     state_reg           <= DONE;
                     done_reg            <= 1'b1;
                     processor_reset_reg <= 1'b0;
                  end else begin
                     state_reg <= ERR;
                     error_reg <= 1'b1;
                  end
               end
`endif
               DONE: begin
                  // A new sync re-arms the loader and puts the processor back in reset.
                  if (is_sync) begin
                     state_reg           <= CNT_LO;
                     done_reg            <= 1'b0;
                     processor_reset_reg <= 1'b1;
                  end
               end
               ERR: begin
                  if (is_sync) begin
                     state_reg <= CNT_LO;
                     error_reg <= 1'b0;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign bus.rx_ready        = 1'b1;
   assign bus.code_we         = code_we_reg;
   assign bus.code_addr       = code_addr_reg;
   assign bus.code_din        = code_din_reg;
   assign bus.processor_reset = processor_reset_reg;
   assign bus.done            = done_reg;
   assign bus.error           = error_reg;
endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: table of framed streams plus hand-written
// sequences for restart, reset mid-load, a full-size image and the checksum byte.
module tb_code_loader;
   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   code_loader_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();

   code_loader #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(1024)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] wa_q[$];
   logic [17:0] wd_q[$];

   always @(negedge clock) begin
      if (bus.code_we === 1'b1) begin
         wa_q.push_back(bus.code_addr);
         wd_q.push_back(bus.code_din);
      end
   end

   typedef struct packed {
      logic [127:0] stream;     // first byte in the most significant used position
      int           nbytes;
      int           max_gap;
      int           csum_start; // first index covered by the checksum, -1 = none
      int           nwr;
      logic [17:0]  wa0;
      logic [17:0]  wd0;
      logic [17:0]  wa1;
      logic [17:0]  wd1;
      bit           exp_done;
      bit           exp_err;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0]  b;
      logic [7:0]  csum;
      logic [17:0] w;
      int          bad_words;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;

      vecs[0] = '{stream: 128'hA5_02_00_34_12_03_FF_FF_00, nbytes: 9, max_gap: 0, csum_start: 1,
                  nwr: 2, wa0: 18'h0, wd0: 18'h31234, wa1: 18'h1, wd1: 18'h0FFFF,
                  exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{stream: 128'h11_A5_01_00_56_34_02, nbytes: 7, max_gap: 3, csum_start: 2,
                  nwr: 1, wa0: 18'h0, wd0: 18'h23456, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b1, exp_err: 1'b0};
      vecs[2] = '{stream: 128'hA5_00_00, nbytes: 3, max_gap: 0, csum_start: -1,
                  nwr: 0, wa0: 18'h0, wd0: 18'h0, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b0, exp_err: 1'b1};
      vecs[3] = '{stream: 128'hA5_01_04, nbytes: 3, max_gap: 0, csum_start: -1,
                  nwr: 0, wa0: 18'h0, wd0: 18'h0, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b0, exp_err: 1'b1};
      vecs[4] = '{stream: 128'hA5_01_00_00_00_00, nbytes: 6, max_gap: 0, csum_start: 1,
                  nwr: 1, wa0: 18'h0, wd0: 18'h0, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b1, exp_err: 1'b0};
      vecs[5] = '{stream: 128'hA5_01_00_00_00_04, nbytes: 6, max_gap: 0, csum_start: -1,
                  nwr: 0, wa0: 18'h0, wd0: 18'h0, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b0, exp_err: 1'b1};
      vecs[6] = '{stream: 128'hA5_01_00_A5_A5_01, nbytes: 6, max_gap: 0, csum_start: 1,
                  nwr: 1, wa0: 18'h0, wd0: 18'h1A5A5, wa1: 18'h0, wd1: 18'h0,
                  exp_done: 1'b1, exp_err: 1'b0};

      // Reset state and 50 idle cycles with no writes
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (50) @(posedge clock);
      @(negedge clock);
      check("idle_writes", wa_q.size(), 0);
      check("idle_preset", bus.processor_reset, 1);
      check("idle_done", bus.done, 0);
      check("idle_error", bus.error, 0);
      check("idle_addr", bus.code_addr, 0);
      check("idle_din", bus.code_din, 0);
      check("idle_rx_ready", bus.rx_ready, 1);
      $display("reset: writes=%0d preset=%0b done=%0b error=%0b",
               wa_q.size(), bus.processor_reset, bus.done, bus.error);
      #1;

      for (int v = 0; v < NV; v++) begin
         wa_q.delete();
         wd_q.delete();
         csum = 8'h00;
         for (int k = 0; k < vecs[v].nbytes; k++) begin
            b = vecs[v].stream[(vecs[v].nbytes - 1 - k) * 8 +: 8];
            if (vecs[v].csum_start >= 0 && k >= vecs[v].csum_start) csum = csum ^ b;
            send_byte(b, (vecs[v].max_gap > 0) ? int'($urandom_range(0, vecs[v].max_gap)) : 0);
         end
`ifdef CODE_LOADER_CHECKSUM_EN
         if (vecs[v].csum_start >= 0) send_byte(csum, 0);
`endif
         settle();
         check($sformatf("v%0d_nwr", v), wa_q.size(), vecs[v].nwr);
         if (vecs[v].nwr >= 1 && wa_q.size() >= 1) begin
            check($sformatf("v%0d_addr0", v), wa_q[0], vecs[v].wa0);
            check($sformatf("v%0d_data0", v), wd_q[0], vecs[v].wd0);
         end
         if (vecs[v].nwr >= 2 && wa_q.size() >= 2) begin
            check($sformatf("v%0d_addr1", v), wa_q[1], vecs[v].wa1);
            check($sformatf("v%0d_data1", v), wd_q[1], vecs[v].wd1);
         end
         check($sformatf("v%0d_done", v), bus.done, vecs[v].exp_done);
         check($sformatf("v%0d_error", v), bus.error, vecs[v].exp_err);
         check($sformatf("v%0d_preset", v), bus.processor_reset, !vecs[v].exp_done);
         $display("vec %0d: writes=%0d done=%0b error=%0b preset=%0b",
                  v, wa_q.size(), bus.done, bus.error, bus.processor_reset);
         #1;
      end

      // In DONE: non-sync bytes ignored, sync restarts on the following cycle
      send_byte(8'h33, 0);
      check("done_ignore_done", bus.done, 1);
      check("done_ignore_preset", bus.processor_reset, 0);
      send_byte(8'hA5, 0);
      check("restart_done", bus.done, 0);
      check("restart_preset", bus.processor_reset, 1);
      $display("restart: done=%0b preset=%0b", bus.done, bus.processor_reset);

      // Reset after 4 of 6 data bytes, then non-sync bytes must be dropped in IDLE
      pulse_reset();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      pulse_reset();
      @(negedge clock);
      check("midrst_preset", bus.processor_reset, 1);
      check("midrst_done", bus.done, 0);
      check("midrst_error", bus.error, 0);
      #1;
      wa_q.delete();
      wd_q.delete();
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h01, 0);
      settle();
      check("midrst_idle_writes", wa_q.size(), 0);
      #1;
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h01, 0);
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(8'h01 ^ 8'h00 ^ 8'h78 ^ 8'h56 ^ 8'h01, 0);
`endif
      settle();
      check("midrst_nwr", wa_q.size(), 1);
      if (wa_q.size() >= 1) begin
         check("midrst_addr", wa_q[0], 0);
         check("midrst_data", wd_q[0], 18'h15678);
      end
      check("midrst_reload_done", bus.done, 1);
      $display("reset mid-load: writes=%0d done=%0b", wa_q.size(), bus.done);
      #1;

      // Largest accepted image: 1024 words, addresses 0..1023
      wa_q.delete();
      wd_q.delete();
      csum = 8'h00 ^ 8'h04;
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < 1024; i++) begin
         w = 18'(i * 263 + 5);
         send_byte(w[7:0], 0);
         send_byte(w[15:8], 0);
         send_byte({6'b0, w[17:16]}, 0);
         csum = csum ^ w[7:0] ^ w[15:8] ^ {6'b0, w[17:16]};
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(csum, 0);
`endif
      settle();
      check("max_nwr", wa_q.size(), 1024);
      bad_words = 0;
      for (int i = 0; i < wa_q.size(); i++) begin
         w = 18'(i * 263 + 5);
         if (wa_q[i] !== 18'(i) || wd_q[i] !== w) bad_words++;
      end
      check("max_bad_words", bad_words, 0);
      if (wa_q.size() > 0) check("max_last_addr", wa_q[wa_q.size() - 1], 18'd1023);
      check("max_done", bus.done, 1);
      $display("max image: writes=%0d bad=%0d done=%0b", wa_q.size(), bad_words, bus.done);
      #1;

`ifdef CODE_LOADER_CHECKSUM_EN
      wa_q.delete();
      wd_q.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      settle();
      check("csum_bad_nwr", wa_q.size(), 1);
      if (wa_q.size() >= 1) check("csum_bad_data", wd_q[0], 18'h30201);
      check("csum_bad_error", bus.error, 1);
      check("csum_bad_preset", bus.processor_reset, 1);
      $display("checksum bad: writes=%0d error=%0b", wa_q.size(), bus.error);
      #1;
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      settle();
      check("csum_ok_done", bus.done, 1);
      check("csum_ok_error", bus.error, 0);
      $display("checksum ok: done=%0b error=%0b", bus.done, bus.error);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
Byte-stream program loader that sits directly upstream of the writable code memory and the processor. It receives a framed byte stream (from a UART receiver), assembles 18-bit instruction words and writes them sequentially into code RAM from address 0. It holds the processor in reset until a complete, valid image has been written.

Parameters:
ADDR_SIZE, 18, width of code_addr
WORD_SIZE, 18, code word width; fixed at 18 (3 bytes per word, top byte carries bits [17:16])
MEM_SIZE, 1024, code RAM depth in words; maximum accepted word count

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts byte; transfer = rx_valid & rx_ready
code_we  output  1  code RAM write strobe, one cycle per word
code_addr  output  ADDR_SIZE  code RAM write address
code_din  output  WORD_SIZE  code RAM write data
processor_reset  output  1  high while loading, in error, or after reset
done  output  1  image loaded, processor released
error  output  1  framing or range error latched

Behaviour:
- One clock (clock). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: code_we=0, code_addr=0, code_din=0, processor_reset=1, done=0, error=0, state=IDLE, word counter=0.
- rx_ready=1 in every state; bytes that do not match the expected frame are consumed and discarded.
- Frame format: sync 0xA5, count_lo, count_hi (N = 16-bit word count, little-endian), then N words of 3 bytes each, low byte first. Byte 2 carries bits [17:16] in [1:0]; its bits [7:2] must be 0.
- States:
  - IDLE: wait for 0xA5; other bytes dropped. On sync -> CNT_LO.
  - CNT_LO: latch low byte -> CNT_HI.
  - CNT_HI: form N. N==0 or N>MEM_SIZE -> ERR, else -> B0 with addr counter=0.
  - B0 -> B1 -> B2: shift bytes into the word. Accepting B2 with nonzero [7:2] -> ERR, with no write.
  - Valid B2: the next cycle drives code_we=1, code_din=word and code_addr=counter for exactly one cycle, then the counter increments.
  - After word N-1 is written: -> DONE (or CSUM if the feature is enabled).
  - DONE: done=1, processor_reset=0. A received 0xA5 restarts the load: processor_reset=1 and done=0 on the cycle after the accept, -> CNT_LO. All other bytes are ignored.
  - ERR: error=1, processor_reset=1, done=0. 0xA5 clears error and -> CNT_LO.
- Write latency: code_we is asserted 1 cycle after the B2 byte transfer. Back-to-back bytes every cycle must be sustained with no loss.
- code_addr holds its last value when code_we=0. Addresses never exceed MEM_SIZE-1.
- Gaps: rx_valid low in any state causes no state change. There is no timeout.
- Reset mid-load: the loader returns to IDLE immediately. Partially written RAM contents are not cleared, and processor_reset stays 1.
- A byte value 0xA5 inside the count or data fields is treated as data, not sync.

Optional Feature:
CODE_LOADER_CHECKSUM_EN
- Defined: after the last data byte, state CSUM expects 1 byte equal to the XOR of all count and data bytes (the sync byte is excluded). Match -> DONE. Mismatch -> ERR; words already written remain in RAM, but the processor stays in reset.
- Undefined: no checksum byte; the loader goes directly to DONE after the last write.

Test Plan:
- Reset with no input: processor_reset=1, done=0, error=0, code_we never asserted over 50 cycles.
- Stream A5 02 00 | 34 12 03 | FF FF 00, back-to-back, checksum off. Required:
  - code_we pulses exactly twice: addr 0 data 0x31234, addr 1 data 0x0FFFF.
  - After the second write: done=1, processor_reset=0.
- Stream 11 A5 01 00 with rx_valid gaps of 0-3 cycles between bytes, then 56 34 02: garbage byte 0x11 ignored, single write addr 0 data 0x23456, done=1.
- Invalid word counts:
  - Count 0x0000 -> error=1, no writes.
  - Count 0x0401 with MEM_SIZE=1024 -> error=1.
  - A following A5 01 00 00 00 00 -> error=0, write addr 0 data 0, done=1.
- High-byte violation: word bytes 00 00 04 -> error=1, no write for that word, processor_reset=1.
- Reset pulsed after 4 of 6 data bytes: state returns to IDLE, processor_reset=1. A subsequent full frame loads from addr 0.
- Checksum (CODE_LOADER_CHECKSUM_EN defined):
  - A5 01 00 01 02 03 04 (checksum = 0x01^0x00^0x01^0x02^0x03 = 0x01 ≠ 0x04) -> error=1 after the write.
  - The same frame with trailing byte 01 -> done=1.
